// File: rtl/midi_pkg.sv
// rtl/midi_pkg.sv - shared types and constants for the MIDI transmit path
package midi_pkg;

    typedef enum logic [1:0] {
        EV_NOTE_OFF = 2'd0,
        EV_NOTE_ON  = 2'd1,
        EV_CTRL     = 2'd2,
        EV_PROG     = 2'd3
    } ev_type_e;

    localparam logic [3:0] NIB_NOTE_OFF = 4'h8;
    localparam logic [3:0] NIB_NOTE_ON  = 4'h9;
    localparam logic [3:0] NIB_CTRL     = 4'hB;
    localparam logic [3:0] NIB_PROG     = 4'hC;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_STAT,
        ST_D1,
        ST_D2
    } enc_state_e;

    typedef struct packed {
        ev_type_e   typ;
        logic [3:0] ch;
        logic [6:0] d1;
        logic [6:0] d2;
    } midi_event_t;

    function automatic logic [7:0] status_byte(input midi_event_t ev);
        logic [3:0] nib;
        case (ev.typ)
            EV_NOTE_OFF: nib = NIB_NOTE_OFF;
            EV_NOTE_ON:  nib = NIB_NOTE_ON;
            EV_CTRL:     nib = NIB_CTRL;
            default:     nib = NIB_PROG;
        endcase
        return {nib, ev.ch};
    endfunction

endpackage

// File: rtl/midi_uart_tx.sv
// rtl/midi_uart_tx.sv - 8N1 byte serialiser, bit period = prescale*8 clocks
module midi_uart_tx
    import midi_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] prescale,
    input  logic        byte_valid,
    output logic        byte_ready,
    input  logic [7:0]  byte_data,
    output logic        txd,
    output logic        active
);

    logic [15:0] period_m1;
    logic [18:0] bit_cnt;
    logic [3:0]  bit_idx;
    logic [8:0]  shreg;
    logic        bit_end;

    assign bit_end = (bit_cnt == {period_m1, 3'b111});
    // Ready in the final stop-bit cycle so a queued byte starts without a gap.
    assign byte_ready = !active || (bit_end && (bit_idx == 4'd9));

    always_ff @(posedge clk) begin
        if (reset) begin
            active    <= 1'b0;
            txd       <= 1'b1;
            period_m1 <= '0;
            bit_cnt   <= '0;
            bit_idx   <= '0;
            shreg     <= '1;
        end else if (byte_valid && byte_ready) begin
            active    <= 1'b1;
            txd       <= 1'b0;
            period_m1 <= (prescale == 16'd0) ? 16'd0 : prescale - 16'd1;
            bit_cnt   <= '0;
            bit_idx   <= '0;
            shreg     <= {1'b1, byte_data};
        end else if (active) begin
            if (bit_end) begin
                bit_cnt <= '0;
                if (bit_idx == 4'd9) begin
                    active <= 1'b0;
                end else begin
                    txd     <= shreg[0];
                    shreg   <= {1'b1, shreg[8:1]};
                    bit_idx <= bit_idx + 4'd1;
                end
            end else begin
                bit_cnt <= bit_cnt + 19'd1;
            end
        end
    end

endmodule

// File: rtl/midi_tx.sv
// rtl/midi_tx.sv - MIDI OUT: event FIFO, running-status encoder, UART serialiser
module midi_tx
    import midi_pkg::*;
#(
    parameter int FIFO_DEPTH     = 4,
    parameter int RUNNING_STATUS = 1,
    parameter int RS_IDLE_BITS   = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] prescale,
    input  logic        ev_valid,
    output logic        ev_ready,
    input  logic [1:0]  ev_type,
    input  logic [3:0]  ev_ch,
    input  logic [6:0]  ev_d1,
    input  logic [6:0]  ev_d2,
    output logic        txd,
    output logic        busy
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW + 1)'(FIFO_DEPTH);
    localparam int IW = (RS_IDLE_BITS > 0) ? $clog2(RS_IDLE_BITS + 1) : 1;
    localparam logic [IW-1:0] IDLE_LIM = IW'(RS_IDLE_BITS);

    midi_event_t       mem [FIFO_DEPTH];
    midi_event_t       ev_in, head, cur;
    logic [AW-1:0]     wr_ptr, rd_ptr;
    logic [AW:0]       count;
    logic              full, empty, push, pop;

    enc_state_e        state, state_nx;
    logic [7:0]        status;
    logic              rs_valid, load_rs, rs_expire;
    logic [7:0]        rs_byte;
    logic              byte_valid, byte_ready, hs, last_done, uart_active;
    logic [7:0]        byte_data;

    logic              idle;
    logic [15:0]       idle_pm1;
    logic [18:0]       tick_cnt;
    logic [IW-1:0]     idle_bits;

    always_comb begin
        ev_in     = '0;
        ev_in.typ = ev_type_e'(ev_type);
        ev_in.ch  = ev_ch;
        ev_in.d1  = ev_d1;
        ev_in.d2  = ev_d2;
    end

    assign full     = (count == DEPTH_C);
    assign empty    = (count == '0);
    assign ev_ready = !full;
    assign push     = ev_valid && !full;
    assign head     = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= ev_in;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
        end
    end

    assign status = status_byte(cur);
    assign hs     = byte_valid && byte_ready;

    always_comb begin
        state_nx   = state;
        byte_valid = 1'b0;
        byte_data  = 8'h00;
        pop        = 1'b0;
        load_rs    = 1'b0;
        last_done  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!empty) begin
                    pop      = 1'b1;
                    state_nx = ST_STAT;
                end
            end
            ST_STAT: begin
                if ((RUNNING_STATUS != 0) && rs_valid && (rs_byte == status)) begin
                    state_nx = ST_D1;
                end else begin
                    byte_valid = 1'b1;
                    byte_data  = status;
                    if (byte_ready) begin
                        load_rs  = 1'b1;
                        state_nx = ST_D1;
                    end
                end
            end
            ST_D1: begin
                byte_valid = 1'b1;
                byte_data  = {1'b0, cur.d1};
                if (byte_ready) begin
                    if (cur.typ == EV_PROG) last_done = 1'b1;
                    else                    state_nx  = ST_D2;
                end
            end
            ST_D2: begin
                byte_valid = 1'b1;
                byte_data  = {1'b0, cur.d2};
                if (byte_ready) last_done = 1'b1;
            end
            default: state_nx = ST_IDLE;
        endcase
        // Chain straight into the next event so back-to-back messages have no gap.
        if (last_done) begin
            if (!empty) begin
                pop      = 1'b1;
                state_nx = ST_STAT;
            end else begin
                state_nx = ST_IDLE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
            cur   <= '0;
        end else begin
            state <= state_nx;
            if (pop) cur <= head;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rs_valid <= 1'b0;
            rs_byte  <= 8'h00;
        end else if (load_rs) begin
            rs_valid <= 1'b1;
            rs_byte  <= status;
        end else if (rs_expire) begin
            rs_valid <= 1'b0;
        end
    end

    // Idle bit-period counter: runs only while nothing is queued or on the wire.
    assign idle      = empty && (state == ST_IDLE) && !uart_active;
    assign idle_pm1  = (prescale == 16'd0) ? 16'd0 : prescale - 16'd1;
    assign rs_expire = (RS_IDLE_BITS > 0) && (idle_bits == IDLE_LIM);

    always_ff @(posedge clk) begin
        if (reset || hs) begin
            tick_cnt  <= '0;
            idle_bits <= '0;
        end else if ((RS_IDLE_BITS > 0) && idle && (idle_bits != IDLE_LIM)) begin
            if (tick_cnt == {idle_pm1, 3'b111}) begin
                tick_cnt  <= '0;
                idle_bits <= idle_bits + IW'(1);
            end else begin
                tick_cnt <= tick_cnt + 19'd1;
            end
        end
    end

    midi_uart_tx u_uart (
        .clk        (clk),
        .reset      (reset),
        .prescale   (prescale),
        .byte_valid (byte_valid),
        .byte_ready (byte_ready),
        .byte_data  (byte_data),
        .txd        (txd),
        .active     (uart_active)
    );

    assign busy = !empty || (state != ST_IDLE) || uart_active;

endmodule

// File: tb/tb_midi_tx.sv
// tb/tb_midi_tx.sv - directed self-checking bench for midi_tx
module tb_midi_tx;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] prescale = 16'd1;
    logic [1:0]  ev_type = 2'd0;
    logic [3:0]  ev_ch = 4'd0;
    logic [6:0]  ev_d1 = 7'd0;
    logic [6:0]  ev_d2 = 7'd0;
    logic        drv_valid = 1'b0;
    int          sel = 0;

    logic ev_valid0, ev_valid1, ev_valid2;
    logic ev_ready0, ev_ready1, ev_ready2;
    logic txd0, txd1, txd2, busy0, busy1, busy2;
    logic txd_sel, busy_sel, ready_sel;

    int tests_run = 0;
    int fails = 0;
    int cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign ev_valid0 = drv_valid && (sel == 0);
    assign ev_valid1 = drv_valid && (sel == 1);
    assign ev_valid2 = drv_valid && (sel == 2);

    always_comb begin
        case (sel)
            0:       begin txd_sel = txd0; busy_sel = busy0; ready_sel = ev_ready0; end
            1:       begin txd_sel = txd1; busy_sel = busy1; ready_sel = ev_ready1; end
            default: begin txd_sel = txd2; busy_sel = busy2; ready_sel = ev_ready2; end
        endcase
    end

    midi_tx #(.FIFO_DEPTH(4), .RUNNING_STATUS(1), .RS_IDLE_BITS(0)) dut0 (
        .clk(clk), .reset(reset), .prescale(prescale), .ev_valid(ev_valid0), .ev_ready(ev_ready0),
        .ev_type(ev_type), .ev_ch(ev_ch), .ev_d1(ev_d1), .ev_d2(ev_d2), .txd(txd0), .busy(busy0));
    midi_tx #(.FIFO_DEPTH(4), .RUNNING_STATUS(0), .RS_IDLE_BITS(0)) dut1 (
        .clk(clk), .reset(reset), .prescale(prescale), .ev_valid(ev_valid1), .ev_ready(ev_ready1),
        .ev_type(ev_type), .ev_ch(ev_ch), .ev_d1(ev_d1), .ev_d2(ev_d2), .txd(txd1), .busy(busy1));
    midi_tx #(.FIFO_DEPTH(4), .RUNNING_STATUS(1), .RS_IDLE_BITS(10)) dut2 (
        .clk(clk), .reset(reset), .prescale(prescale), .ev_valid(ev_valid2), .ev_ready(ev_ready2),
        .ev_type(ev_type), .ev_ch(ev_ch), .ev_d1(ev_d1), .ev_d2(ev_d2), .txd(txd2), .busy(busy2));

    // Frame decoder for the selected DUT: 8 clocks per bit, sample mid-bit.
    logic [7:0] rxq[$];
    int         rx_start[$];
    bit         mact = 1'b0;
    int         mj = 0;
    logic [7:0] msh = 8'h00;

    always @(negedge clk) begin
        if (reset) begin
            mact = 1'b0;
        end else if (!mact) begin
            if (txd_sel === 1'b0) begin
                mact = 1'b1;
                mj = 0;
                rx_start.push_back(cyc);
            end
        end else begin
            mj++;
            if ((mj % 8 == 4) && (mj / 8 >= 1) && (mj / 8 <= 8)) msh[mj / 8 - 1] = txd_sel;
            if (mj == 76) begin
                rxq.push_back(msh);
                mact = 1'b0;
            end
        end
    end

    task automatic push(input logic [1:0] t, input logic [3:0] ch, input logic [6:0] d1,
                        input logic [6:0] d2, output bit ok);
        int n = 0;
        @(negedge clk);
        ev_type = t; ev_ch = ch; ev_d1 = d1; ev_d2 = d2;
        drv_valid = 1'b1;
        while (!ready_sel && n < 5000) begin
            @(negedge clk);
            n++;
        end
        ok = ready_sel;
        @(posedge clk);
        #1 drv_valid = 1'b0;
    endtask

    task automatic wait_idle(output bit ok);
        int n = 0;
        while (busy_sel && n < 5000) begin
            @(posedge clk);
            n++;
        end
        #1 ok = !busy_sel;
    endtask

    task automatic clear_rx();
        rxq.delete();
        rx_start.delete();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk);
        #1;
        tests_run++;
        if (txd0 !== 1'b1) begin fails++; $display("FAIL reset_txd got %b want 1", txd0); end
        tests_run++;
        if (busy0 !== 1'b0) begin fails++; $display("FAIL reset_busy got %b want 0", busy0); end
        tests_run++;
        if (ev_ready0 !== 1'b1) begin fails++; $display("FAIL reset_ready got %b want 1", ev_ready0); end
    endtask

    task automatic test_note_on();
        logic [7:0] exp [3] = '{8'h90, 8'h3C, 8'h64};
        logic [7:0] got;
        bit ok;
        sel = 0;
        clear_rx();
        push(2'd1, 4'd0, 7'd60, 7'd100, ok);
        tests_run++;
        if (!ok) begin fails++; $display("FAIL note_on_accept got 0 want 1"); end
        @(posedge clk);
        #1;
        tests_run++;
        if (txd_sel !== 1'b1) begin fails++; $display("FAIL latency_n1 txd got %b want 1", txd_sel); end
        @(posedge clk);
        #1;
        tests_run++;
        if (txd_sel !== 1'b0) begin fails++; $display("FAIL latency_n2 txd got %b want 0", txd_sel); end
        repeat (239) @(posedge clk);
        #1;
        tests_run++;
        if (busy_sel !== 1'b1) begin fails++; $display("FAIL busy_s239 got %b want 1", busy_sel); end
        @(posedge clk);
        #1;
        tests_run++;
        if (busy_sel !== 1'b0) begin fails++; $display("FAIL busy_s240 got %b want 0", busy_sel); end
        tests_run++;
        if (rxq.size() != 3) begin fails++; $display("FAIL note_on_count got %0d want 3", rxq.size()); end
        for (int i = 0; i < 3; i++) begin
            got = (i < rxq.size()) ? rxq[i] : 8'hxx;
            tests_run++;
            if (got !== exp[i]) begin fails++; $display("FAIL note_on_byte%0d got %h want %h", i, got, exp[i]); end
        end
    endtask

    task automatic test_running_status();
        logic [7:0] exp_rs [2] = '{8'h40, 8'h7F};
        logic [7:0] exp_nrs [3] = '{8'h90, 8'h40, 8'h7F};
        logic [7:0] got;
        bit ok, idle_ok;
        sel = 0;
        clear_rx();
        push(2'd1, 4'd0, 7'd64, 7'd127, ok);
        wait_idle(idle_ok);
        tests_run++;
        if (!(ok && idle_ok)) begin fails++; $display("FAIL rs_timeout got stuck want idle"); end
        tests_run++;
        if (rxq.size() != 2) begin fails++; $display("FAIL rs_count got %0d want 2", rxq.size()); end
        for (int i = 0; i < 2; i++) begin
            got = (i < rxq.size()) ? rxq[i] : 8'hxx;
            tests_run++;
            if (got !== exp_rs[i]) begin fails++; $display("FAIL rs_byte%0d got %h want %h", i, got, exp_rs[i]); end
        end
        sel = 1;
        clear_rx();
        push(2'd1, 4'd0, 7'd64, 7'd127, ok);
        wait_idle(idle_ok);
        tests_run++;
        if (rxq.size() != 3) begin fails++; $display("FAIL nrs_count got %0d want 3", rxq.size()); end
        for (int i = 0; i < 3; i++) begin
            got = (i < rxq.size()) ? rxq[i] : 8'hxx;
            tests_run++;
            if (got !== exp_nrs[i]) begin fails++; $display("FAIL nrs_byte%0d got %h want %h", i, got, exp_nrs[i]); end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp [5] = '{8'hC9, 8'h05, 8'h89, 8'h3C, 8'h00};
        logic [7:0] got;
        bit ok, idle_ok;
        sel = 0;
        clear_rx();
        push(2'd3, 4'd9, 7'd5, 7'd0, ok);
        push(2'd0, 4'd9, 7'd60, 7'd0, ok);
        wait_idle(idle_ok);
        tests_run++;
        if (rxq.size() != 5) begin fails++; $display("FAIL b2b_count got %0d want 5", rxq.size()); end
        for (int i = 0; i < 5; i++) begin
            got = (i < rxq.size()) ? rxq[i] : 8'hxx;
            tests_run++;
            if (got !== exp[i]) begin fails++; $display("FAIL b2b_byte%0d got %h want %h", i, got, exp[i]); end
        end
        for (int i = 0; i + 1 < rx_start.size(); i++) begin
            tests_run++;
            if (rx_start[i + 1] - rx_start[i] != 80)
                begin fails++; $display("FAIL b2b_gap%0d got %0d want 80", i, rx_start[i + 1] - rx_start[i]); end
        end
    endtask

    task automatic test_fifo_full();
        logic [7:0] exp [13];
        logic [7:0] got;
        bit ok, idle_ok;
        sel = 0;
        clear_rx();
        exp[0] = 8'h90;
        for (int i = 0; i < 6; i++) begin
            exp[1 + 2 * i] = 8'(10 + i);
            exp[2 + 2 * i] = 8'(20 + i);
        end
        for (int i = 0; i < 5; i++) push(2'd1, 4'd0, 7'(10 + i), 7'(20 + i), ok);
        tests_run++;
        if (ev_ready0 !== 1'b0) begin fails++; $display("FAIL full_ready got %b want 0", ev_ready0); end
        push(2'd1, 4'd0, 7'd15, 7'd25, ok);
        tests_run++;
        if (!ok) begin fails++; $display("FAIL full_sixth_accept got 0 want 1"); end
        wait_idle(idle_ok);
        tests_run++;
        if (rxq.size() != 13) begin fails++; $display("FAIL full_count got %0d want 13", rxq.size()); end
        for (int i = 0; i < 13; i++) begin
            got = (i < rxq.size()) ? rxq[i] : 8'hxx;
            tests_run++;
            if (got !== exp[i]) begin fails++; $display("FAIL full_byte%0d got %h want %h", i, got, exp[i]); end
        end
    endtask

    task automatic test_rs_timeout();
        logic [7:0] got;
        bit ok, idle_ok;
        sel = 2;
        clear_rx();
        push(2'd1, 4'd0, 7'd60, 7'd100, ok);
        wait_idle(idle_ok);
        clear_rx();
        repeat (96) @(posedge clk);
        push(2'd1, 4'd0, 7'd60, 7'd100, ok);
        wait_idle(idle_ok);
        got = (rxq.size() > 0) ? rxq[0] : 8'hxx;
        tests_run++;
        if (rxq.size() != 3 || got !== 8'h90)
            begin fails++; $display("FAIL to_expired got %0d bytes first %h want 3 bytes first 90", rxq.size(), got); end
        clear_rx();
        repeat (40) @(posedge clk);
        push(2'd1, 4'd0, 7'd60, 7'd100, ok);
        wait_idle(idle_ok);
        got = (rxq.size() > 0) ? rxq[0] : 8'hxx;
        tests_run++;
        if (rxq.size() != 2 || got !== 8'h3C)
            begin fails++; $display("FAIL to_kept got %0d bytes first %h want 2 bytes first 3c", rxq.size(), got); end
    endtask

    task automatic test_reset_mid_byte();
        logic [7:0] exp [3] = '{8'h90, 8'h3C, 8'h64};
        logic [7:0] got;
        bit ok, idle_ok;
        int n = 0;
        sel = 0;
        clear_rx();
        push(2'd1, 4'd0, 7'd60, 7'd100, ok);
        while (txd_sel !== 1'b0 && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        tests_run++;
        if (txd_sel !== 1'b0) begin fails++; $display("FAIL mid_start got %b want 0", txd_sel); end
        repeat (43) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        tests_run++;
        if (txd0 !== 1'b1) begin fails++; $display("FAIL mid_reset_txd got %b want 1", txd0); end
        tests_run++;
        if (busy0 !== 1'b0) begin fails++; $display("FAIL mid_reset_busy got %b want 0", busy0); end
        tests_run++;
        if (ev_ready0 !== 1'b1) begin fails++; $display("FAIL mid_reset_ready got %b want 1", ev_ready0); end
        reset = 1'b0;
        clear_rx();
        push(2'd1, 4'd0, 7'd60, 7'd100, ok);
        wait_idle(idle_ok);
        tests_run++;
        if (rxq.size() != 3) begin fails++; $display("FAIL post_reset_count got %0d want 3", rxq.size()); end
        for (int i = 0; i < 3; i++) begin
            got = (i < rxq.size()) ? rxq[i] : 8'hxx;
            tests_run++;
            if (got !== exp[i]) begin fails++; $display("FAIL post_reset_byte%0d got %h want %h", i, got, exp[i]); end
        end
    endtask

    initial begin
        test_reset();
        test_note_on();
        test_running_status();
        test_back_to_back();
        test_fifo_full();
        test_rs_timeout();
        test_reset_mid_byte();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
